// File: rtl/bus_mailbox_if.sv
// CPU-side memory bus strobes and stall line shared by the mailbox and its initiator.
// The bidirectional data bus stays a plain inout port on the responder.
interface bus_mailbox_if;
    logic [15:0] a;
    logic        n_oe;
    logic        n_we;
    logic        n_rdy;

    modport master (output a, n_oe, n_we, input n_rdy);
    modport slave  (input a, n_oe, n_we, output n_rdy);
endinterface

// File: rtl/bus_mailbox.sv
// Two-register mailbox on the CPU bus: DATA pushes a TX FIFO / pops an RX FIFO,
// STATUS reports FIFO flags and flushes; accesses are stretched by n_rdy wait states.
module bus_mailbox #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DEPTH       = 8
) (
    input  logic         clk,
    input  logic         rst,
    bus_mailbox_if.slave cpu,
    inout  wire  [7:0]   d,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [7:0]    rdData_q;
    logic [PW-1:0] txWr_q, txRd_q, rxWr_q, rxRd_q;
    logic [PW-1:0] txWr_d, txRd_d, rxWr_d, rxRd_d;
    logic [7:0]    txMem [DEPTH];
    logic [7:0]    rxMem [DEPTH];

    logic sel, rd, wr, acc, isStatus;
    logic txEmpty, txFull, rxEmpty, rxFull;
    logic commitOk, commit, txPush, txPop, rxPush, rxPop, flush;
    logic [7:0] rdValue;

    assign sel      = (cpu.a[15:1] == BASE_ADDR[15:1]);
    assign rd       = sel & ~cpu.n_oe & cpu.n_we;
    assign wr       = sel & ~cpu.n_we & cpu.n_oe;
    assign acc      = rd | wr;
    assign isStatus = cpu.a[0];

    // Full when the wrap bits differ but the index bits match.
    assign txEmpty = (txWr_q == txRd_q);
    assign txFull  = (txWr_q[AW] != txRd_q[AW]) && (txWr_q[AW-1:0] == txRd_q[AW-1:0]);
    assign rxEmpty = (rxWr_q == rxRd_q);
    assign rxFull  = (rxWr_q[AW] != rxRd_q[AW]) && (rxWr_q[AW-1:0] == rxRd_q[AW-1:0]);

    assign commitOk = !(wr && !isStatus && txFull);
    assign commit   = (state_q == ST_WAIT) && acc && (cnt_q == 4'd0) && commitOk;
    assign txPush   = commit & wr & ~isStatus;
    assign flush    = commit & wr & isStatus & d[7];
    assign txPop    = tx_valid & tx_ready;
    assign rxPush   = rx_valid & rx_ready;
    assign rxPop    = commit & rd & ~isStatus & ~rxEmpty;

    assign rdValue = isStatus ? {5'b0, txEmpty, ~txFull, ~rxEmpty}
                              : (rxEmpty ? 8'hFF : rxMem[rxRd_q[AW-1:0]]);

    assign tx_valid = ~txEmpty;
    assign tx_data  = txEmpty ? 8'h00 : txMem[txRd_q[AW-1:0]];
    assign rx_ready = ~rxFull;

    assign cpu.n_rdy = ~rst & ((state_q == ST_WAIT) | ((state_q == ST_IDLE) & acc));
    assign d         = ((state_q == ST_DONE) && rd) ? rdData_q : 8'hzz;

    always_comb begin
        txWr_d = txWr_q;
        txRd_d = txRd_q;
        rxWr_d = rxWr_q;
        rxRd_d = rxRd_q;
        if (flush) begin
            txWr_d = '0;
            txRd_d = '0;
            rxWr_d = '0;
            rxRd_d = '0;
        end else begin
            if (txPush) txWr_d = txWr_q + PW'(1);
            if (txPop)  txRd_d = txRd_q + PW'(1);
            if (rxPush) rxWr_d = rxWr_q + PW'(1);
            if (rxPop)  rxRd_d = rxRd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txWr_q <= '0;
            txRd_q <= '0;
            rxWr_q <= '0;
            rxRd_q <= '0;
        end else begin
            txWr_q <= txWr_d;
            txRd_q <= txRd_d;
            rxWr_q <= rxWr_d;
            rxRd_q <= rxRd_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (txPush) txMem[txWr_q[AW-1:0]] <= d;
        if (rxPush) rxMem[rxWr_q[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            rdData_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= 4'(WAIT_STATES);
                    end
                end
                ST_WAIT: begin
                    if (!acc) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (commitOk) begin
                        state_q <= ST_DONE;
                        if (rd) rdData_q <= rdValue;
                    end
                end
                ST_DONE: begin
                    if (!acc) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_mailbox.sv
// Scoreboard bench for bus_mailbox: expected read bytes and TX stream bytes are
// queued when stimulus is issued and compared when the DUT delivers them.
module tb_bus_mailbox;
    localparam int WAIT_STATES = 2;
    localparam int DEPTH       = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_mailbox_if mb();
    wire  [7:0] d;
    logic [7:0] dDrv;
    logic       dOe;
    assign d = dOe ? dDrv : 8'hzz;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int total = 0;
    int bad   = 0;
    logic [7:0] txQ[$];
    logic [7:0] readQ[$];

    bus_mailbox #(
        .BASE_ADDR  (16'hFF00),
        .WAIT_STATES(WAIT_STATES),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu     (mb),
        .d       (d),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Every byte leaving the TX stream must match the oldest byte the CPU wrote.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (txQ.size() == 0) checkOutput("txUnexpected", 32'(tx_data), 32'hFFFF_FFFF);
            else checkOutput("txStream", 32'(tx_data), 32'(txQ.pop_front()));
        end
    end

    // Runs one CPU access from posedge+1; optionally pulses tx_ready after edge pulseAt.
    task automatic applyStimulus(input logic [15:0] addr, input bit isWrite, input logic [7:0] wdata,
                                 input int pulseAt, output logic [7:0] rdata, output int highSamples);
        bit done = 1'b0;
        rdata = 8'h00;
        highSamples = 0;
        mb.a = addr;
        mb.n_oe = isWrite;
        mb.n_we = !isWrite;
        dDrv = wdata;
        dOe = isWrite;
        #1 checkOutput("nRdyComb", 32'(mb.n_rdy), 32'd1);
        for (int i = 1; i <= 64 && !done; i++) begin
            @(posedge clk);
            #1;
            if (pulseAt >= 0) tx_ready = (i == pulseAt);
            @(negedge clk);
            if (mb.n_rdy) highSamples++;
            else begin
                done = 1'b1;
                rdata = d;
            end
        end
        if (!done) checkOutput("accessTimeout", 32'd0, 32'd1);
        mb.n_oe = 1'b1;
        mb.n_we = 1'b1;
        dOe = 1'b0;
        if (pulseAt >= 0) tx_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] data);
        logic [7:0] rdata;
        int hs;
        applyStimulus(addr, 1'b1, data, -1, rdata, hs);
        checkOutput("wrLatency", 32'(hs), 32'(WAIT_STATES + 1));
    endtask

    task automatic cpuRead(input logic [15:0] addr, input logic [7:0] expected, input string tag);
        logic [7:0] rdata;
        int hs;
        readQ.push_back(expected);
        applyStimulus(addr, 1'b0, 8'h00, -1, rdata, hs);
        checkOutput(tag, 32'(rdata), 32'(readQ.pop_front()));
        checkOutput("rdLatency", 32'(hs), 32'(WAIT_STATES + 1));
    endtask

    task automatic rxSend(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic txDrain(input int n);
        tx_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    task automatic probeNoAccess(input logic [15:0] addr, input logic oe, input logic we,
                                 input logic [7:0] data, input string tag);
        int hs = 0;
        mb.a = addr;
        mb.n_oe = oe;
        mb.n_we = we;
        dDrv = data;
        dOe = !we;
        #1 if (mb.n_rdy) hs++;
        repeat (5) begin
            @(negedge clk);
            if (mb.n_rdy) hs++;
        end
        checkOutput(tag, 32'(hs), 32'd0);
        mb.n_oe = 1'b1;
        mb.n_we = 1'b1;
        dOe = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] rdata;
        int hs;
        rst = 1'b1;
        mb.a = 16'h0000;
        mb.n_oe = 1'b1;
        mb.n_we = 1'b1;
        dOe = 1'b0;
        dDrv = 8'h00;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        checkOutput("rstNRdy", 32'(mb.n_rdy), 32'd0);
        checkOutput("rstTxValid", 32'(tx_valid), 32'd0);
        checkOutput("rstRxReady", 32'(rx_ready), 32'd1);
        checkOutput("rstTxData", 32'(tx_data), 32'h00);
        cpuRead(16'hFF01, 8'h06, "statusReset");

        txQ.push_back(8'hA5);
        cpuWrite(16'hFF00, 8'hA5);
        checkOutput("txValid", 32'(tx_valid), 32'd1);
        checkOutput("txHead", 32'(tx_data), 32'hA5);
        txDrain(1);
        checkOutput("txPopped", 32'(tx_valid), 32'd0);
        checkOutput("txQueueLeft", 32'(txQ.size()), 32'd0);

        rxSend(8'h3C);
        cpuRead(16'hFF01, 8'h07, "statusRx");
        cpuRead(16'hFF00, 8'h3C, "rxData");
        cpuRead(16'hFF01, 8'h06, "statusRxEmpty");
        cpuRead(16'hFF00, 8'hFF, "rxEmptyRead");

        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            txQ.push_back(b);
            cpuWrite(16'hFF00, b);
        end
        cpuRead(16'hFF01, 8'h00, "statusTxFull");
        txQ.push_back(8'h99);
        applyStimulus(16'hFF00, 1'b1, 8'h99, 10, rdata, hs);
        checkOutput("blockedStall", 32'(hs), 32'd11);
        cpuRead(16'hFF01, 8'h00, "statusStillFull");
        txDrain(DEPTH);
        checkOutput("txDrained", 32'(tx_valid), 32'd0);
        checkOutput("txQueueEmpty", 32'(txQ.size()), 32'd0);

        for (int i = 0; i < DEPTH; i++) rxSend(8'(8'h10 + i));
        checkOutput("rxFullReady", 32'(rx_ready), 32'd0);
        cpuRead(16'hFF01, 8'h07, "statusRxFull");
        for (int i = 0; i < DEPTH; i++) cpuRead(16'hFF00, 8'(8'h10 + i), "rxFifo");
        cpuRead(16'hFF00, 8'hFF, "rxDrained");

        rxSend(8'h55);
        cpuWrite(16'hFF00, 8'h77);
        probeNoAccess(16'hFF01, 1'b0, 1'b0, 8'h80, "illegalStrobes");
        probeNoAccess(16'hFF02, 1'b0, 1'b1, 8'h00, "otherAddr");
        cpuRead(16'hFF01, 8'h03, "statusBeforeFlush");
        cpuWrite(16'hFF01, 8'h80);
        cpuRead(16'hFF01, 8'h06, "statusFlushed");
        checkOutput("txValidFlushed", 32'(tx_valid), 32'd0);
        checkOutput("txDataFlushed", 32'(tx_data), 32'h00);

        rxSend(8'h5A);
        mb.a = 16'hFF00;
        mb.n_oe = 1'b0;
        mb.n_we = 1'b1;
        @(posedge clk);
        #1 checkOutput("inWait", 32'(mb.n_rdy), 32'd1);
        rst = 1'b1;
        #1 checkOutput("rstMidNRdy", 32'(mb.n_rdy), 32'd0);
        mb.n_oe = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        cpuRead(16'hFF01, 8'h06, "statusAfterRst");
        cpuRead(16'hFF00, 8'hFF, "dataAfterRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
